// File: rtl/cfg_loader_pkg.sv
// Shared definitions for the configuration bank loader: FSM state encoding
// and the even-parity helper used on incoming row data.
package cfg_loader_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARMED = 3'd1,
      SETUP = 3'd2,
      PULSE = 3'd3,
      HOLD  = 3'd4,
      DONE  = 3'd5
   } state_t;

   // Rows are zero-extended to this width before reduction; zeros do not alter parity.
   localparam int PARITY_MAX_W = 1024;

   function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/wl_decoder.sv
// Registered one-hot word-line decoder; every output clears asynchronously
// on reset_n so a pulse in flight is cut off immediately.
module wl_decoder #(
   parameter int NUM_WL = 32,
   parameter int ADDR_W = $clog2(NUM_WL)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              en,
   input  logic [ADDR_W-1:0] addr,
   output logic [NUM_WL-1:0] wl
);

   logic [NUM_WL-1:0] wl_reg;

   // One flop per row, each comparing against its own index, so at most one can be set.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_WL; gi++) begin : g_row
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               wl_reg[gi] <= 1'b0;
            end else begin
               wl_reg[gi] <= en && (addr == ADDR_W'(gi));
            end
         end
      end
   endgenerate

   assign wl = wl_reg;

endmodule

// File: rtl/config_bank_loader.sv
// Loads bitstream rows into config_latch cells with setup/pulse/hold framing on BL/WL.
// Define CFG_LOADER_PARITY_EN to add an even-parity MSB on cfg_data, checked per row.
module config_bank_loader
   import cfg_loader_pkg::*;
#(
   parameter int NUM_BL          = 16,
   parameter int NUM_WL          = 32,
   parameter int WL_PULSE_CYCLES = 2,
   parameter int ADDR_W          = $clog2(NUM_WL)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [ADDR_W-1:0] cfg_addr,
`ifdef CFG_LOADER_PARITY_EN
   input  logic [NUM_BL:0]   cfg_data,
`else
   input  logic [NUM_BL-1:0] cfg_data,
`endif
   input  logic              cfg_last,
   output logic [NUM_BL-1:0] bl,
   output logic [NUM_WL-1:0] wl,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [ADDR_W:0]   rows_written
);

   localparam int CNT_W = $clog2(WL_PULSE_CYCLES + 1);

   state_t            state_reg, state_next;
   logic [ADDR_W-1:0] addr_reg;
   logic [NUM_BL-1:0] bl_reg;
   logic              last_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              ready_reg;
   logic              busy_reg;
   logic              done_reg;
   logic              err_reg;
   logic [ADDR_W:0]   rows_reg;

   logic [NUM_BL-1:0] data_bits;
   logic              parity_ok;
   logic              addr_ok;
   logic              row_ok;
   logic              offer;

`ifdef CFG_LOADER_PARITY_EN
   assign data_bits = cfg_data[NUM_BL-1:0];
   assign parity_ok = (cfg_data[NUM_BL] == even_parity(PARITY_MAX_W'(data_bits)));
`else
   assign data_bits = cfg_data;
   assign parity_ok = 1'b1;
`endif

   // ADDR_W may be wider than the row count needs, so out-of-range rows are possible.
   assign addr_ok = ({1'b0, cfg_addr} < (ADDR_W + 1)'(NUM_WL));
   assign row_ok  = addr_ok && parity_ok;
   assign offer   = (state_reg == ARMED) && cfg_valid;

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE: begin
            if (start) state_next = ARMED;
         end
         ARMED: begin
            if (cfg_valid) begin
               if (row_ok)        state_next = SETUP;
               else if (cfg_last) state_next = DONE;
            end
         end
         SETUP: state_next = PULSE;
         PULSE: begin
            if (cnt_reg == '0) state_next = HOLD;
         end
         HOLD:    state_next = last_reg ? DONE : ARMED;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Status outputs are registered from state_next so they line up with the state they describe.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= IDLE;
         addr_reg  <= '0;
         bl_reg    <= '0;
         last_reg  <= 1'b0;
         cnt_reg   <= '0;
         ready_reg <= 1'b0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
         err_reg   <= 1'b0;
         rows_reg  <= '0;
      end else begin
         state_reg <= state_next;
         ready_reg <= (state_next == ARMED);
         busy_reg  <= (state_next != IDLE);
         done_reg  <= (state_next == DONE);

         if (state_reg == IDLE && start) begin
            err_reg  <= 1'b0;
            rows_reg <= '0;
         end

         if (offer) begin
            if (row_ok) begin
               addr_reg <= cfg_addr;
               bl_reg   <= data_bits;
               last_reg <= cfg_last;
            end else begin
               err_reg <= 1'b1;
            end
         end

         if (state_reg == SETUP) begin
            cnt_reg <= CNT_W'(WL_PULSE_CYCLES - 1);
         end else if (state_reg == PULSE && cnt_reg != '0) begin
            cnt_reg <= cnt_reg - CNT_W'(1);
         end

         if (state_reg == HOLD && rows_reg < (ADDR_W + 1)'(NUM_WL)) begin
            rows_reg <= rows_reg + (ADDR_W + 1)'(1);
         end
      end
   end

   wl_decoder #(
      .NUM_WL (NUM_WL),
      .ADDR_W (ADDR_W)
   ) u_wl_decoder (
      .clk     (clk),
      .reset_n (reset_n),
      .en      (state_next == PULSE),
      .addr    (addr_reg),
      .wl      (wl)
   );

   assign cfg_ready    = ready_reg;
   assign bl           = bl_reg;
   assign busy         = busy_reg;
   assign done         = done_reg;
   assign err          = err_reg;
   assign rows_written = rows_reg;

endmodule

// File: tb/tb_config_bank_loader.sv
// Scoreboard bench for config_bank_loader: stimulus queues expected WL pulses and
// done reports; a negedge monitor compares them as the DUT produces them.
module tb_config_bank_loader;

   localparam int NUM_BL = 16;
   localparam int NUM_WL = 32;
   localparam int P      = 2;
   localparam int AW     = 6;
`ifdef CFG_LOADER_PARITY_EN
   localparam int DW = NUM_BL + 1;
`else
   localparam int DW = NUM_BL;
`endif

   typedef struct packed {
      logic [AW-1:0]     addr;
      logic [NUM_BL-1:0] data;
   } row_t;

   typedef struct packed {
      logic [AW:0] rows;
      logic        err;
   } done_t;

   logic              clk       = 1'b0;
   logic              reset_n   = 1'b0;
   logic              start     = 1'b0;
   logic              cfg_valid = 1'b0;
   logic              cfg_last  = 1'b0;
   logic [AW-1:0]     cfg_addr  = '0;
   logic [DW-1:0]     cfg_data  = '0;
   logic              cfg_ready;
   logic              busy;
   logic              done;
   logic              err;
   logic [NUM_BL-1:0] bl;
   logic [NUM_WL-1:0] wl;
   logic [AW:0]       rows_written;

   int   checks     = 0;
   int   errors     = 0;
   int   cyc        = 0;
   int   model_rows = 0;
   logic model_err  = 1'b0;
   row_t  exp_q[$];
   done_t done_q[$];

   config_bank_loader #(
      .NUM_BL          (NUM_BL),
      .NUM_WL          (NUM_WL),
      .WL_PULSE_CYCLES (P),
      .ADDR_W          (AW)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .start        (start),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_addr     (cfg_addr),
      .cfg_data     (cfg_data),
      .cfg_last     (cfg_last),
      .bl           (bl),
      .wl           (wl),
      .busy         (busy),
      .done         (done),
      .err          (err),
      .rows_written (rows_written)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] make_data(input logic [NUM_BL-1:0] d);
`ifdef CFG_LOADER_PARITY_EN
      return {^d, d};
`else
      return d;
`endif
   endfunction

   task automatic do_start();
      @(posedge clk); #1;
      start = 1'b1;
      model_rows = 0;
      model_err  = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Presents one row and returns #1 after the accepting edge; cfg_valid is left high.
   task automatic send_row(input int addr, input logic [DW-1:0] word, input logic last,
                           input bit legal, input int gap, output int acc);
      int n;
      if (gap > 0) begin
         cfg_valid = 1'b0;
         repeat (gap) begin @(posedge clk); #1; end
      end
      cfg_valid = 1'b1;
      cfg_addr  = AW'(addr);
      cfg_data  = word;
      cfg_last  = last;
      n = 0;
      @(negedge clk);
      while (!cfg_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!cfg_ready) begin
         check("accept_timeout", 0, 1);
         cfg_valid = 1'b0;
         acc = cyc;
         return;
      end
      if (legal) begin
         exp_q.push_back(row_t'{addr: AW'(addr), data: word[NUM_BL-1:0]});
         if (model_rows < NUM_WL) model_rows++;
      end else begin
         model_err = 1'b1;
      end
      if (last) done_q.push_back(done_t'{rows: (AW+1)'(model_rows), err: model_err});
      @(posedge clk); #1;
      acc = cyc;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("idle_timeout", busy, 0);
   endtask

   // Monitor: pairs each completed WL pulse and each done pulse with the queued expectation.
   initial begin
      logic [NUM_WL-1:0] wl_prev;
      logic [NUM_WL-1:0] cur_wl;
      logic [NUM_BL-1:0] cur_bl;
      int   width;
      int   idx;
      logic done_prev;
      row_t  r;
      done_t d;
      wl_prev   = '0;
      cur_wl    = '0;
      cur_bl    = '0;
      width     = 0;
      done_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            wl_prev   = '0;
            width     = 0;
            done_prev = 1'b0;
         end else begin
            if (wl != '0) begin
               check("wl_onehot", $countones(wl), 1);
               if (wl_prev == '0) begin
                  cur_wl = wl;
                  cur_bl = bl;
                  width  = 1;
               end else begin
                  width++;
                  check("wl_stable", wl, cur_wl);
                  check("bl_held", bl, cur_bl);
               end
            end else if (wl_prev != '0) begin
               idx = 0;
               for (int k = 0; k < NUM_WL; k++) if (cur_wl[k]) idx = k;
               if (exp_q.size() == 0) begin
                  check("unexpected_pulse_row", idx, 255);
               end else begin
                  r = exp_q.pop_front();
                  check("pulse_addr", idx, r.addr);
                  check("pulse_data", cur_bl, r.data);
                  check("pulse_width", width, P);
               end
            end
            wl_prev = wl;
            if (done) begin
               check("done_single_cycle", done_prev, 0);
               if (done_q.size() == 0) begin
                  check("unexpected_done", 1, 0);
               end else begin
                  d = done_q.pop_front();
                  check("done_rows", rows_written, d.rows);
                  check("done_err", err, d.err);
               end
            end
            done_prev = done;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int acc;
      int prev;
      logic [DW-1:0] w;
      logic [NUM_BL-1:0] dv;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready", cfg_ready, 0);
      check("rst_bl", bl, 0);
      check("rst_wl", wl, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_rows", rows_written, 0);
      reset_n = 1'b1;

      // Single row: addr 3, data A5C3, last
      do_start();
      check("armed_ready", cfg_ready, 1);
      check("armed_busy", busy, 1);
      send_row(3, make_data(16'hA5C3), 1'b1, 1'b1, 0, acc);
      cfg_valid = 1'b0;
      check("setup_bl", bl, 16'hA5C3);
      check("setup_wl", wl, 0);
      check("setup_ready", cfg_ready, 0);
      @(posedge clk); #1;
      check("pulse1_wl", wl, 32'h8);
      @(posedge clk); #1;
      check("pulse2_wl", wl, 32'h8);
      @(posedge clk); #1;
      check("hold_wl", wl, 0);
      check("hold_bl", bl, 16'hA5C3);
      @(posedge clk); #1;
      check("done_at_a5", done, 1);
      @(posedge clk); #1;
      check("done_ends", done, 0);
      check("idle_busy", busy, 0);
      check("single_rows", rows_written, 1);
      check("single_err", err, 0);
      check("bl_kept", bl, 16'hA5C3);

      // Full load: 32 back-to-back rows plus a duplicate to hit saturation
      do_start();
      prev = 0;
      for (int i = 0; i <= NUM_WL; i++) begin
         dv = NUM_BL'(16'h3C00 ^ (i * 257));
         send_row((i < NUM_WL) ? i : NUM_WL - 1, make_data(dv), 1'(i == NUM_WL), 1'b1, 0, acc);
         if (i > 0) check("row_interval", acc - prev, P + 3);
         prev = acc;
      end
      cfg_valid = 1'b0;
      wait_idle();
      check("full_rows_sat", rows_written, NUM_WL);
      check("full_err", err, 0);

      // Illegal address then legal last row
      do_start();
      send_row(40, make_data(16'hDEAD), 1'b0, 1'b0, 0, acc);
      check("bad_err", err, 1);
      check("bad_wl", wl, 0);
      check("bad_back_armed", cfg_ready, 1);
      send_row(5, make_data(16'h1234), 1'b1, 1'b1, 0, acc);
      cfg_valid = 1'b0;
      wait_idle();
      check("bad_rows", rows_written, 1);
      check("bad_err_sticky", err, 1);

      // Reset mid-pulse
      do_start();
      send_row(7, make_data(16'h0F0F), 1'b1, 1'b1, 0, acc);
      cfg_valid = 1'b0;
      @(posedge clk); #1;
      check("mid_wl7", wl, 32'h80);
      #2;
      reset_n = 1'b0;
      exp_q.delete();
      done_q.delete();
      #1;
      check("async_wl", wl, 0);
      check("async_bl", bl, 0);
      check("async_ready", cfg_ready, 0);
      check("async_busy", busy, 0);
      check("async_rows", rows_written, 0);
      repeat (2) @(posedge clk);
      #1;
      reset_n   = 1'b1;
      cfg_valid = 1'b1;
      cfg_addr  = AW'(7);
      cfg_data  = make_data(16'h0F0F);
      cfg_last  = 1'b1;
      repeat (4) begin
         @(negedge clk);
         check("post_rst_no_ready", cfg_ready, 0);
         check("post_rst_no_wl", wl, 0);
      end
      cfg_valid = 1'b0;

      // Backpressure with random gaps and start pulsed while busy
      do_start();
      send_row(9, make_data(16'h1111), 1'b0, 1'b1, int'($urandom_range(0, 4)), acc);
      send_row(9, make_data(16'h2222), 1'b0, 1'b1, int'($urandom_range(0, 4)), acc);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_start_err", err, 0);
      send_row(10, make_data(16'h3333), 1'b0, 1'b1, int'($urandom_range(0, 4)), acc);
      send_row(20, make_data(16'h4444), 1'b1, 1'b1, int'($urandom_range(0, 4)), acc);
      cfg_valid = 1'b0;
      wait_idle();
      check("bp_rows", rows_written, 4);
      check("bp_err", err, 0);

`ifdef CFG_LOADER_PARITY_EN
      // Parity: wrong then correct parity on the same data
      do_start();
      w = make_data(16'h0001);
      w[NUM_BL] = 1'b0;
      send_row(12, w, 1'b0, 1'b0, 0, acc);
      check("par_err", err, 1);
      check("par_no_wl", wl, 0);
      w[NUM_BL] = 1'b1;
      send_row(12, w, 1'b1, 1'b1, 0, acc);
      cfg_valid = 1'b0;
      wait_idle();
      check("par_rows", rows_written, 1);
`else
      w = make_data(16'h0001);
      check("noparity_width", $bits(w), NUM_BL);
`endif

      repeat (3) @(posedge clk);
      check("exp_q_empty", exp_q.size(), 0);
      check("done_q_empty", done_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/config_bank_loader.md
# config_bank_loader

Sequencer that writes a bitstream, one row per transfer, into a memory-bank array of `config_latch` cells through their bit-line (BL) and word-line (WL) pins. It sits between the bitstream source (JTAG/scan front end or testbench driver) and the fabric's BL/WL bus. It guarantees the setup / pulse / hold ordering the latches need, drives only one WL at a time, and reports completion and errors.

## Interface
Parameters:
- `NUM_BL`, default 16: bit lines, i.e. row data width.
- `NUM_WL`, default 32: word lines, i.e. rows. Must be ≥ 2.
- `WL_PULSE_CYCLES`, default 2: WL high time in clocks. Must be ≥ 1.
- `ADDR_W`, default `$clog2(NUM_WL)`: row address width.

Ports:
- `clk`  in  1  the single clock; all logic is rising-edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to arm a new load. Honoured only in IDLE.
- `cfg_valid`  in  1  row transfer valid.
- `cfg_ready`  out  1  loader can accept a row.
- `cfg_addr`  in  ADDR_W  target WL index.
- `cfg_data`  in  NUM_BL  row data (plus 1 parity MSB when the parity feature is compiled in).
- `cfg_last`  in  1  marks the final row of the load.
- `bl`  out  NUM_BL  bit-line drive.
- `wl`  out  NUM_WL  word-line drive; at most one bit is high at any time.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when the load completes.
- `err`  out  1  sticky error flag; cleared by an accepted `start`.
- `rows_written`  out  ADDR_W+1  count of rows actually pulsed; cleared by an accepted `start`.

## Operation
- States:
  - IDLE: `start` moves to ARMED; clears `err` and `rows_written`.
  - ARMED: `cfg_ready`=1.
    - A transfer (`cfg_valid`&&`cfg_ready`) with a legal row registers addr, data and last, then goes to SETUP.
    - If `cfg_addr` ≥ NUM_WL: `err` is set, no WL is pulsed, and the row is consumed. If last is set the next state is DONE, otherwise ARMED.
  - SETUP (1 cycle): `bl` = registered data; `wl` = 0.
  - PULSE (WL_PULSE_CYCLES cycles): `wl[addr]` = 1; `bl` held.
  - HOLD (1 cycle): `wl` = 0; `bl` held; `rows_written`++. Next state is DONE if last, else ARMED.
  - DONE (1 cycle): `done`=1; next state IDLE.
- `cfg_ready` is 0 in every state except ARMED.
- `cfg_ready` does not depend combinationally on `cfg_valid`.
- `bl` keeps its last driven value until the next SETUP. It is 0 after reset.
- `start` outside IDLE is ignored. It is not queued.
- `rows_written` saturates at NUM_WL. Duplicate addresses are legal and each one counts.

## Timing
- Reset values: `cfg_ready`=0, `bl`=0, `wl`=0, `busy`=0, `done`=0, `err`=0, `rows_written`=0. State is IDLE.
- Reset asserted mid-pulse forces `wl` low asynchronously, in the same instant, not at the next clock.
- Cycle timing:
  - `start` sampled at cycle t gives ARMED (`cfg_ready`=1) at t+1.
  - A row accepted at cycle a gives SETUP at a+1, PULSE at a+2 … a+1+P, and HOLD at a+2+P.
  - If the row was not last, ARMED returns at a+3+P.
  - If the row was last, DONE is at a+3+P and IDLE at a+4+P.
- Row throughput: one row every P+3 clocks, where P = WL_PULSE_CYCLES.
- A rejected row (bad address or parity) takes 1 cycle: ARMED at a+1, or DONE at a+1 if last.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Configuration
- `CFG_LOADER_PARITY_EN` defined:
  - `cfg_data` is NUM_BL+1 bits wide; the MSB is even parity over the low NUM_BL bits.
  - A mismatch is treated exactly like an illegal address: `err` is set, no pulse, the row is consumed, and `rows_written` is not incremented.
- `CFG_LOADER_PARITY_EN` undefined: `cfg_data` is NUM_BL bits wide and no parity check is made.

## Structure
- Shared package `cfg_loader_pkg` holds:
  - the state enum (IDLE, ARMED, SETUP, PULSE, HOLD, DONE);
  - the parity helper function.
- One sub-module, `wl_decoder`: registered one-hot decoder taking ADDR_W plus an enable to NUM_WL outputs, with asynchronous clear on `reset_n`. It keeps the one-hot guarantee local and easy to check.
- Pulse counter width is `$clog2(WL_PULSE_CYCLES+1)`.

## Test plan
- Single row, NUM_BL=16, P=2:
  - Stimulus: `start`; row addr=3, data=16'hA5C3, last=1.
  - Required: `bl`=A5C3 from a+1; `wl[3]` high exactly at a+2..a+3; `done` pulse at a+5; `rows_written`=1; `err`=0.
- Full load:
  - Stimulus: 32 back-to-back rows, addr 0..31, `cfg_valid` held high.
  - Required: `cfg_ready` duty of 1 in 5; at most one `wl` bit ever high; `rows_written`=32; single `done`.
- Illegal address:
  - Stimulus: addr=40 with NUM_WL=32, then a legal row addr=5 with last.
  - Required: `err`=1 with no `wl` activity for the bad row; row 5 programmed; `rows_written`=1; `err` still 1 after `done`.
- Reset mid-pulse:
  - Stimulus: deassert `reset_n` while `wl[7]` is high.
  - Required: `wl`=0 immediately; all outputs at reset values; a row offered afterwards is not accepted until a new `start`.
- Backpressure and start rules:
  - Stimulus: `cfg_valid` toggling randomly; `start` pulsed while busy.
  - Required: no row lost or duplicated; `start` while busy has no effect on `err` or `rows_written`.
- Parity (with `CFG_LOADER_PARITY_EN`):
  - Stimulus: data 16'h0001 with parity bit 0.
  - Required: `err`=1; no `wl` pulse.
  - Stimulus: same data with parity bit 1.
  - Required: row programmed normally.
